mips_multicycle_ctrl: RTL and testbench

//  Multicycle MIPS control FSM. Drives the ALU (ALUCtrl code, operand selects) and consumes its Zero flag.

---
 rtl/mips_multicycle_ctrl_pkg.sv | 108 ++++++++++
 rtl/mips_multicycle_ctrl_if.sv | 34 +++
 rtl/mips_multicycle_ctrl_alu_ctrl_decode.sv | 43 ++++
 rtl/mips_multicycle_ctrl.sv | 109 ++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared types for the multicycle MIPS controller: state encoding, opcode/funct
// constants, ALU operation codes and the Moore control word per state.
package mips_multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_RWB    = 4'd8,
        S_BRANCH = 4'd9,
        S_IEXEC  = 4'd10,
        S_IWB    = 4'd11,
        S_JUMP   = 4'd12,
        S_TRAP   = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_NOR = 4'd12;

    typedef enum logic [2:0] {
        CLS_NONE,
        CLS_ADD,
        CLS_SUB,
        CLS_RTYPE,
        CLS_ITYPE
    } alu_class_t;

    typedef struct packed {
        logic [3:0] alu_ctrl;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic       pc_en;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       trap;
    } ctrl_t;

    function automatic alu_class_t alu_class(input state_t s);
        case (s)
            S_FETCH, S_DECODE, S_MEMADR: return CLS_ADD;
            S_BRANCH:                    return CLS_SUB;
            S_EXEC:                      return CLS_RTYPE;
            S_IEXEC:                     return CLS_ITYPE;
            default:                     return CLS_NONE;
        endcase
    endfunction

    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

    // Moore part of the control word; the FETCH/BRANCH qualifiers are added at the top.
    function automatic ctrl_t moore_ctrl(input state_t s, input logic [3:0] alu);
        ctrl_t c;
        c          = '0;
        c.alu_ctrl = alu;
        case (s)
            S_FETCH:  begin c.mem_read  = 1'b1; c.alu_src_b  = 2'b01; end
            S_DECODE: begin c.alu_src_b = 2'b11; end
            S_MEMADR: begin c.alu_src_a = 1'b1; c.alu_src_b  = 2'b10; end
            S_MEMRD:  begin c.mem_read  = 1'b1; c.iord       = 1'b1;  end
            S_MEMWB:  begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1;  end
            S_MEMWR:  begin c.mem_write = 1'b1; c.iord       = 1'b1;  end
            S_EXEC:   begin c.alu_src_a = 1'b1; end
            S_RWB:    begin c.reg_write = 1'b1; c.reg_dst    = 1'b1;  end
            S_BRANCH: begin c.alu_src_a = 1'b1; c.pc_source  = 2'b01; end
            S_IEXEC:  begin c.alu_src_a = 1'b1; c.alu_src_b  = 2'b10; end
            S_IWB:    begin c.reg_write = 1'b1; end
            S_JUMP:   begin c.pc_source = 2'b10; c.pc_en     = 1'b1;  end
            S_TRAP:   begin c.trap      = 1'b1; end
            default:  ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle: instruction fields and flags in,
// ALU/memory/register-file strobes and debug state out.
interface mips_multicycle_ctrl_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic [3:0] alu_ctrl;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       pc_en;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       trap;
    logic [3:0] state;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output alu_ctrl, alu_src_a, alu_src_b, pc_source, pc_en, iord, mem_read,
               mem_write, ir_write, reg_dst, mem_to_reg, reg_write, trap, state
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  alu_ctrl, alu_src_a, alu_src_b, pc_source, pc_en, iord, mem_read,
               mem_write, ir_write, reg_dst, mem_to_reg, reg_write, trap, state
    );
endinterface

// File: rtl/mips_multicycle_ctrl_alu_ctrl_decode.sv
// Maps {state class, opcode, funct} to an ALU operation and flags unknown encodings.
// Purely combinational, no handshake.
module mips_multicycle_ctrl_alu_ctrl_decode
    import mips_multicycle_ctrl_pkg::*;
(
    input  alu_class_t cls,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [3:0] alu_ctrl,
    output logic       illegal
);

    always_comb begin
        alu_ctrl = ALU_AND;
        illegal  = 1'b0;
        case (cls)
            CLS_ADD: alu_ctrl = ALU_ADD;
            CLS_SUB: alu_ctrl = ALU_SUB;
            CLS_RTYPE: begin
                case (funct)
                    FN_ADD:  alu_ctrl = ALU_ADD;
                    FN_SUB:  alu_ctrl = ALU_SUB;
                    FN_AND:  alu_ctrl = ALU_AND;
                    FN_OR:   alu_ctrl = ALU_OR;
                    FN_NOR:  alu_ctrl = ALU_NOR;
                    FN_SLT:  alu_ctrl = ALU_SLT;
                    default: illegal  = 1'b1;
                endcase
            end
            CLS_ITYPE: begin
                case (opcode)
                    OP_ADDI: alu_ctrl = ALU_ADD;
                    OP_SLTI: alu_ctrl = ALU_SLT;
                    OP_ANDI: alu_ctrl = ALU_AND;
                    OP_ORI:  alu_ctrl = ALU_OR;
                    default: illegal  = 1'b1;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM with registered Moore outputs and a memory-timeout trap.
// One state per cycle; memory states hold until mem_ready or the wait limit.
module mips_multicycle_ctrl
    import mips_multicycle_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT_LIMIT = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mips_multicycle_ctrl_if.master bus
);

    localparam logic [7:0] WAIT_LIMIT = 8'(MEM_WAIT_LIMIT);
    localparam bit         WAIT_EN    = (MEM_WAIT_LIMIT != 0);

    state_t     state_q;
    state_t     state_nxt;
    logic [7:0] wait_cnt_q;
    logic       funct_bad_q;
    logic       br_ne_q;
    ctrl_t      ctrl_q;
    logic       timeout;
    logic [3:0] dec_alu;
    logic       dec_illegal;

    // Decode against the state being entered so the control word is ready on entry.
    mips_multicycle_ctrl_alu_ctrl_decode u_dec (
        .cls      (alu_class(state_nxt)),
        .opcode   (bus.opcode),
        .funct    (bus.funct),
        .alu_ctrl (dec_alu),
        .illegal  (dec_illegal)
    );

    assign timeout = WAIT_EN && (wait_cnt_q == WAIT_LIMIT) && !bus.mem_ready;

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE:   state_nxt = S_FETCH;
            S_FETCH:  if (bus.mem_ready) state_nxt = S_DECODE;
                      else if (timeout)  state_nxt = S_TRAP;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW:                      state_nxt = S_MEMADR;
                    OP_RTYPE:                          state_nxt = S_EXEC;
                    OP_BEQ, OP_BNE:                    state_nxt = S_BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_nxt = S_IEXEC;
                    OP_J:                              state_nxt = S_JUMP;
                    default:                           state_nxt = S_TRAP;
                endcase
            end
            S_MEMADR: state_nxt = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (bus.mem_ready) state_nxt = S_MEMWB;
                      else if (timeout)  state_nxt = S_TRAP;
            S_MEMWB:  state_nxt = S_FETCH;
            S_MEMWR:  if (bus.mem_ready) state_nxt = S_FETCH;
                      else if (timeout)  state_nxt = S_TRAP;
            S_EXEC:   state_nxt = funct_bad_q ? S_TRAP : S_RWB;
            S_RWB:    state_nxt = S_FETCH;
            S_BRANCH: state_nxt = S_FETCH;
            S_IEXEC:  state_nxt = S_IWB;
            S_IWB:    state_nxt = S_FETCH;
            S_JUMP:   state_nxt = S_FETCH;
            S_TRAP:   state_nxt = S_TRAP;
            default:  state_nxt = S_TRAP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wait_cnt_q  <= 8'd0;
            funct_bad_q <= 1'b0;
            br_ne_q     <= 1'b0;
            ctrl_q      <= '0;
        end else begin
            state_q <= state_nxt;
            ctrl_q  <= moore_ctrl(state_nxt, dec_alu);
            if (state_nxt == S_EXEC)
                funct_bad_q <= dec_illegal;
            if (state_nxt == S_BRANCH)
                br_ne_q <= (bus.opcode == OP_BNE);
            // Every memory state is entered from a different state, so a change clears the count.
            if (state_nxt != state_q)
                wait_cnt_q <= 8'd0;
            else if (is_mem_state(state_q))
                wait_cnt_q <= wait_cnt_q + 8'd1;
        end
    end

    assign bus.alu_ctrl   = ctrl_q.alu_ctrl;
    assign bus.alu_src_a  = ctrl_q.alu_src_a;
    assign bus.alu_src_b  = ctrl_q.alu_src_b;
    assign bus.pc_source  = ctrl_q.pc_source;
    assign bus.iord       = ctrl_q.iord;
    assign bus.mem_read   = ctrl_q.mem_read;
    assign bus.mem_write  = ctrl_q.mem_write;
    assign bus.reg_dst    = ctrl_q.reg_dst;
    assign bus.mem_to_reg = ctrl_q.mem_to_reg;
    assign bus.reg_write  = ctrl_q.reg_write;
    assign bus.trap       = ctrl_q.trap;
    assign bus.state      = state_q;
    assign bus.ir_write   = (state_q == S_FETCH) && bus.mem_ready;
    assign bus.pc_en      = ctrl_q.pc_en
                          | ((state_q == S_FETCH)  && bus.mem_ready)
                          | ((state_q == S_BRANCH) && (bus.zero ^ br_ne_q));

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomised instruction stream against a per-instruction state-sequence model,
// plus directed reset, branch, illegal-opcode and memory-timeout cases.
module tb_mips_multicycle_ctrl;

    localparam int LIMIT = 4;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    mips_multicycle_ctrl_if ifc ();

    mips_multicycle_ctrl #(.MEM_WAIT_LIMIT(LIMIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire logic [17:0] obs_w = {ifc.alu_ctrl, ifc.alu_src_a, ifc.alu_src_b, ifc.pc_source,
                               ifc.pc_en, ifc.iord, ifc.mem_read, ifc.mem_write, ifc.ir_write,
                               ifc.reg_dst, ifc.mem_to_reg, ifc.reg_write, ifc.trap};

    typedef struct {
        int   st;
        logic rdy;
    } cyc_t;

    cyc_t       q[$];
    logic [5:0] cur_op;
    logic [5:0] cur_fn;
    int         zmode = -1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] fn_alu(input logic [5:0] fn);
        case (fn)
            6'h20:   return 4'd2;
            6'h22:   return 4'd6;
            6'h24:   return 4'd0;
            6'h25:   return 4'd1;
            6'h27:   return 4'd12;
            6'h2A:   return 4'd7;
            default: return 4'd0;
        endcase
    endfunction

    function automatic bit fn_legal(input logic [5:0] fn);
        return fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
    endfunction

    function automatic logic [3:0] op_alu(input logic [5:0] op);
        case (op)
            6'h08:   return 4'd2;
            6'h0A:   return 4'd7;
            6'h0C:   return 4'd0;
            6'h0D:   return 4'd1;
            default: return 4'd0;
        endcase
    endfunction

    // Expected output vector for a state number, straight from the state/action table.
    function automatic logic [17:0] ref_out(input int st, input logic [5:0] op, input logic [5:0] fn,
                                            input logic z, input logic rdy);
        logic [3:0] alu;
        logic       sa;
        logic [1:0] sb, ps;
        logic       pe, iord, mr, mw, irw, rd, m2r, rw, tr;
        {alu, sa, sb, ps, pe, iord, mr, mw, irw, rd, m2r, rw, tr} = '0;
        case (st)
            1:  begin mr = 1; sb = 2'b01; alu = 4'd2; irw = rdy; pe = rdy; end
            2:  begin sb = 2'b11; alu = 4'd2; end
            3:  begin sa = 1; sb = 2'b10; alu = 4'd2; end
            4:  begin mr = 1; iord = 1; end
            5:  begin rw = 1; m2r = 1; end
            6:  begin mw = 1; iord = 1; end
            7:  begin sa = 1; alu = fn_alu(fn); end
            8:  begin rw = 1; rd = 1; end
            9:  begin sa = 1; alu = 4'd6; ps = 2'b01; pe = (op == 6'h04) ? z : ~z; end
            10: begin sa = 1; sb = 2'b10; alu = op_alu(op); end
            11: begin rw = 1; end
            12: begin ps = 2'b10; pe = 1; end
            13: begin tr = 1; end
            default: ;
        endcase
        return {alu, sa, sb, ps, pe, iord, mr, mw, irw, rd, m2r, rw, tr};
    endfunction

    task automatic push(input int st, input logic rdy);
        cyc_t c;
        c.st  = st;
        c.rdy = rdy;
        q.push_back(c);
    endtask

    task automatic push_r(input int st);
        push(st, 1'($urandom_range(0, 1)));
    endtask

    // A memory phase stalled for 'stall' cycles; beyond the limit it ends in TRAP.
    task automatic push_mem(input int st, input int stall, output bit trapped);
        trapped = 0;
        if (stall > LIMIT) begin
            for (int i = 0; i <= LIMIT; i++) push(st, 1'b0);
            trapped = 1;
        end else begin
            for (int i = 0; i < stall; i++) push(st, 1'b0);
            push(st, 1'b1);
        end
    endtask

    task automatic gen(input logic [5:0] op, input logic [5:0] fn, input int s_f, input int s_m,
                       output bit trapped);
        cur_op = op;
        cur_fn = fn;
        push_mem(1, s_f, trapped);
        if (!trapped) begin
            push_r(2);
            case (op)
                6'h23: begin push_r(3); push_mem(4, s_m, trapped); if (!trapped) push_r(5); end
                6'h2B: begin push_r(3); push_mem(6, s_m, trapped); end
                6'h00: begin push_r(7); if (fn_legal(fn)) push_r(8); else trapped = 1; end
                6'h04, 6'h05:               push_r(9);
                6'h08, 6'h0A, 6'h0C, 6'h0D: begin push_r(10); push_r(11); end
                6'h02:                      push_r(12);
                default:                    trapped = 1;
            endcase
        end
    endtask

    task automatic play();
        logic z;
        foreach (q[i]) begin
            @(negedge clk);
            z = (zmode < 0) ? 1'($urandom_range(0, 1)) : zmode[0];
            ifc.opcode    = cur_op;
            ifc.funct     = cur_fn;
            ifc.zero      = z;
            ifc.mem_ready = q[i].rdy;
            #1;
            chk("state", 32'(ifc.state), 32'(q[i].st));
            chk($sformatf("outs_s%0d", q[i].st), 32'(obs_w),
                32'(ref_out(q[i].st, cur_op, cur_fn, z, q[i].rdy)));
        end
        q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n         = 1'b0;
        ifc.mem_ready = 1'b1;
        ifc.zero      = 1'b1;
        #1;
        chk("rst_state", 32'(ifc.state), 32'd0);
        chk("rst_outs", 32'(obs_w), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int s_f,
                             input int s_m, input int ntrap);
        bit tr;
        gen(op, fn, s_f, s_m, tr);
        play();
        if (tr) begin
            for (int i = 0; i < ntrap; i++) push_r(13);
            play();
            do_reset();
            push_r(0);
        end
    endtask

    function automatic int rstall();
        if ($urandom_range(0, 7) == 0) return int'($urandom_range(5, 7));
        return int'($urandom_range(0, 4));
    endfunction

    initial begin
        logic [5:0] legal_fn [6];
        logic [5:0] op;
        logic [5:0] fn;
        legal_fn = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
        rst_n         = 1'b0;
        ifc.opcode    = '0;
        ifc.funct     = '0;
        ifc.zero      = 1'b0;
        ifc.mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("init_state", 32'(ifc.state), 32'd0);
        chk("init_outs", 32'(obs_w), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        push_r(0);

        run_instr(6'h00, 6'h20, 0, 0, 0);   // add, zero-wait memory
        run_instr(6'h23, 6'h00, 0, 3, 0);   // lw, MEMRD stalled 3 cycles
        zmode = 1;
        run_instr(6'h04, 6'h00, 0, 0, 0);   // beq taken
        run_instr(6'h05, 6'h00, 0, 0, 0);   // bne not taken
        zmode = -1;
        run_instr(6'h3F, 6'h00, 0, 0, 100); // illegal opcode, trap holds
        run_instr(6'h02, 6'h00, 5, 0, 3);   // FETCH never ready -> timeout
        run_instr(6'h02, 6'h00, 4, 0, 0);   // ready on the limit cycle wins

        // Abort a load in the middle of MEMRD.
        cur_op = 6'h23;
        cur_fn = 6'h00;
        push(1, 1'b1); push_r(2); push_r(3); push(4, 1'b0); push(4, 1'b0);
        play();
        do_reset();
        push_r(0);

        for (int n = 0; n < 300; n++) begin
            fn = 6'h00;
            case ($urandom_range(0, 11))
                0:  begin op = 6'h00; fn = legal_fn[$urandom_range(0, 5)]; end
                1:  begin op = 6'h00; fn = 6'($urandom); end
                2:  op = 6'h23;
                3:  op = 6'h2B;
                4:  op = 6'h04;
                5:  op = 6'h05;
                6:  op = 6'h08;
                7:  op = 6'h0A;
                8:  op = 6'h0C;
                9:  op = 6'h0D;
                10: op = 6'h02;
                default: op = 6'($urandom);
            endcase
            run_instr(op, fn, rstall(), rstall(), int'($urandom_range(1, 4)));
        end
        play();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
